seg_value_encoder: RTL and testbench

- Upstream feeder of the two-digit seven-segment multiplexer: converts a binary value (0..99) into a 14-bit pair of segment patterns, both7seg[13:7] = tens digit, both7seg[6:0] = units digit.
- Conversion is iterative shift-add-3 (double dabble), one bit per cycle, then a registered segment-encode step.
- Start/busy/done handshake; output register holds the last completed result so the multiplexer always sees a stable pattern.

---
 rtl/seg_value_encoder.sv | 148 ++++++++++++++
 tb/tb_seg_value_encoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_value_encoder.sv
// Converts a binary value (0..99) into a registered two-digit seven-segment pattern.
// The conversion is iterative double dabble, followed by one registered encode step.
module seg_value_encoder #(
    parameter int WIDTH    = 7,
    parameter int BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic [13:0]      both7seg,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ENC   = 2'd2
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [9:0]       scratch_r;
    logic [9:0]       adj_s;
    logic [2:0]       bit_cnt_r;
    logic [13:0]      seg_r;
    logic [13:0]      seg_s;
    logic             busy_r;
    logic             done_r;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            add3 = nib + 4'd3;
        end else begin
            add3 = nib;
        end
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] dig);
        case (dig)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Add-3 correction of the BCD digits ahead of the next shift; hundreds never exceeds 1.
    always_comb begin
        adj_s = {scratch_r[9:8], add3(scratch_r[7:4]), add3(scratch_r[3:0])};
    end

    // Segment pattern for the finished BCD result: dash on overflow, optional blank tens.
    always_comb begin
        seg_s = 14'h0000;
        if (scratch_r[9:8] != 2'd0) begin
            seg_s = 14'h2040;
        end else if ((BLANK_LZ != 0) && (scratch_r[7:4] == 4'd0)) begin
            seg_s = {7'h00, seg7(scratch_r[3:0])};
        end else begin
            seg_s = {seg7(scratch_r[7:4]), seg7(scratch_r[3:0])};
        end
    end

    // Next-state logic of the conversion sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == LAST_BIT) begin
                    state_s = ST_ENC;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_ENC:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs; the display register only changes on the encode edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r   <= '0;
            scratch_r <= 10'd0;
            bit_cnt_r <= 3'd0;
            seg_r     <= 14'h0000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        shreg_r   <= value;
                        scratch_r <= 10'd0;
                        bit_cnt_r <= 3'd0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    {scratch_r, shreg_r} <= {adj_s[8:0], shreg_r, 1'b0};
                    bit_cnt_r            <= bit_cnt_r + 3'd1;
                end
                ST_ENC: begin
                    seg_r  <= seg_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign both7seg = seg_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_seg_value_encoder.sv
// Self-checking bench for seg_value_encoder: two instances (leading-zero blanking on/off)
// share the same stimulus and are compared against a decimal-arithmetic reference model.
module tb_seg_value_encoder;

    localparam int W = 7;

    logic        clk;
    logic        rst;
    logic        load;
    logic [W-1:0] value;
    logic [13:0] seg_b;
    logic        busy_b;
    logic        done_b;
    logic [13:0] seg_n;
    logic        busy_n;
    logic        done_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg_value_encoder #(.WIDTH(W), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .both7seg(seg_b), .busy(busy_b), .done(done_b)
    );

    seg_value_encoder #(.WIDTH(W), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .both7seg(seg_n), .busy(busy_n), .done(done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits from plain division, then table lookup.
    function automatic logic [13:0] model(input int v, input bit blank);
        int h;
        int t;
        int u;
        logic [6:0] hi;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (h != 0) return 14'h2040;
        hi = (blank && t == 0) ? 7'h00 : seg_tab[t];
        return {hi, seg_tab[u]};
    endfunction

    // Issue one load pulse and wait (bounded) for done; cycles counts edges after the accept edge.
    task automatic do_conv(input int v, output int cycles);
        value = 7'(v);
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        value = 7'($urandom);
        cycles = 0;
        while (done_b !== 1'b1 && cycles < 30) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; load = 1'b0; value = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (seg_b !== 14'h0000 || busy_b !== 1'b0 || done_b !== 1'b0 || seg_n !== 14'h0000) begin
            n_fail++;
            $display("FAIL reset: seg=%h busy=%b done=%b seg_nb=%h, required 0000/0/0/0000",
                     seg_b, busy_b, done_b, seg_n);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (seg_b !== 14'h0000 || busy_b !== 1'b0 || done_b !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_idle: %0d cycles changed, required 0", bad);
        end
    endtask

    task automatic test_basic();
        int bad;
        value = 7'd42; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; value = 7'd13;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy_b !== 1'b1 || done_b !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL basic_busy: %0d of 8 cycles not busy-only, required 0", bad);
        end
        n_checks++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || seg_b !== 14'h335B) begin
            n_fail++;
            $display("FAIL basic_done: done=%b busy=%b seg=%h, required 1/0/335b", done_b, busy_b, seg_b);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done_b !== 1'b0 || seg_b !== 14'h335B) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b seg=%h, required 0/335b", done_b, seg_b);
        end
    endtask

    task automatic test_blanking();
        int cyc;
        int vals [3] = '{7, 0, 10};
        for (int i = 0; i < 3; i++) begin
            do_conv(vals[i], cyc);
            n_checks++;
            if (seg_b !== model(vals[i], 1'b1) || seg_n !== model(vals[i], 1'b0)) begin
                n_fail++;
                $display("FAIL blank_%0d: seg=%h seg_nb=%h, required %h/%h", vals[i], seg_b, seg_n,
                         model(vals[i], 1'b1), model(vals[i], 1'b0));
            end
        end
        do_conv(7, cyc);
        n_checks++;
        if (seg_b !== 14'h0007 || seg_n !== 14'h1F87) begin
            n_fail++;
            $display("FAIL blank_7_const: seg=%h seg_nb=%h, required 0007/1f87", seg_b, seg_n);
        end
        do_conv(0, cyc);
        n_checks++;
        if (seg_b !== 14'h003F) begin
            n_fail++;
            $display("FAIL blank_0_const: seg=%h, required 003f", seg_b);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        int vals [4] = '{100, 127, 99, 101};
        logic [13:0] req [4] = '{14'h2040, 14'h2040, 14'h37EF, 14'h2040};
        for (int i = 0; i < 4; i++) begin
            do_conv(vals[i], cyc);
            n_checks++;
            if (seg_b !== req[i] || seg_n !== req[i]) begin
                n_fail++;
                $display("FAIL overflow_%0d: seg=%h seg_nb=%h, required %h", vals[i], seg_b, seg_n, req[i]);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        int v;
        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(127, 0));
            do_conv(v, cyc);
            n_checks++;
            if (cyc != W + 1 || seg_b !== model(v, 1'b1) || seg_n !== model(v, 1'b0)) begin
                n_fail++;
                $display("FAIL random_%0d: latency=%0d seg=%h seg_nb=%h, required %0d/%h/%h", v, cyc,
                         seg_b, seg_n, W + 1, model(v, 1'b1), model(v, 1'b0));
            end
        end
    endtask

    task automatic test_load_while_busy();
        int pulses;
        int overlap;
        value = 7'd42; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        value = 7'd55; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        pulses = 0; overlap = 0;
        for (int i = 0; i < 16; i++) begin
            if (done_b === 1'b1) pulses++;
            if (done_b === 1'b1 && busy_b === 1'b1) overlap++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (pulses != 1 || overlap != 0 || seg_b !== 14'h335B) begin
            n_fail++;
            $display("FAIL load_busy: pulses=%0d overlap=%0d seg=%h, required 1/0/335b", pulses, overlap, seg_b);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int pulses;
        value = 7'd99; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (seg_b !== 14'h0000 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: seg=%h busy=%b done=%b, required 0000/0/0", seg_b, busy_b, done_b);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_b === 1'b1 || seg_b !== 14'h0000) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: %0d cycles with done/seg activity, required 0", pulses);
        end
        do_conv(99, cyc);
        n_checks++;
        if (cyc != 8 || seg_b !== 14'h37EF) begin
            n_fail++;
            $display("FAIL reset_mid_reload: latency=%0d seg=%h, required 8/37ef", cyc, seg_b);
        end
    endtask

    task automatic test_back_to_back();
        int last;
        int gaps_bad;
        int pulses;
        value = 7'd58; load = 1'b1;
        last = 0; gaps_bad = 0; pulses = 0;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            if (done_b === 1'b1) begin
                if (pulses > 0 && t - last != W + 2) gaps_bad++;
                pulses++;
                last = t;
            end
        end
        load = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        n_checks++;
        if (pulses != 4 || gaps_bad != 0 || seg_b !== model(58, 1'b1)) begin
            n_fail++;
            $display("FAIL back_to_back: pulses=%0d bad_gaps=%0d seg=%h, required 4/0/%h",
                     pulses, gaps_bad, seg_b, model(58, 1'b1));
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = 7'd0;
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_random();
        test_load_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
